// File: rtl/toothless_pkg.sv
`default_nettype none
// ============================================================================
// toothless_pkg : shared types and constants for the toothless core
// Revision 1.0
// ============================================================================
package toothless_pkg;

  localparam logic [1:0] DATA_TYPE_BYTE = 2'b00;
  localparam logic [1:0] DATA_TYPE_HALF = 2'b01;
  localparam logic [1:0] DATA_TYPE_WORD = 2'b10;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    REQ         = 2'd1,
    WAIT_RVALID = 2'd2,
    ERR         = 2'd3
  } lsu_state_e;

endpackage
`default_nettype wire

// File: rtl/lsu_rdata_align.sv
`default_nettype none
// ============================================================================
// lsu_rdata_align : selects the addressed byte/half of a read word and extends it
// Revision 1.0
// ============================================================================
module lsu_rdata_align
  import toothless_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  offset,
  input  logic [1:0]  data_type,
  input  logic        sign_ext,
  output logic [31:0] result
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = rdata[7:0];
    case (offset)
      2'd0:    w_byte = rdata[7:0];
      2'd1:    w_byte = rdata[15:8];
      2'd2:    w_byte = rdata[23:16];
      default: w_byte = rdata[31:24];
    endcase
  end

  assign w_half = offset[1] ? rdata[31:16] : rdata[15:0];

  always_comb begin
    result = rdata;
    case (data_type)
      DATA_TYPE_BYTE: result = {{24{sign_ext & w_byte[7]}}, w_byte};
      DATA_TYPE_HALF: result = {{16{sign_ext & w_half[15]}}, w_half};
      default:        result = rdata;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/lsu.sv
`default_nettype none
// ============================================================================
// lsu : load-store unit, one decoded access -> one req/gnt/rvalid transaction
// Revision 1.0
// ============================================================================
module lsu
  import toothless_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  lsu_req_i,
  input  logic                  lsu_we_i,
  input  logic [1:0]            lsu_type_i,
  input  logic                  lsu_sign_ext_i,
  input  logic [ADDR_WIDTH-1:0] lsu_addr_i,
  input  logic [DATA_WIDTH-1:0] lsu_wdata_i,
  output logic                  lsu_busy_o,
  output logic                  lsu_done_o,
  output logic                  lsu_err_o,
  output logic [DATA_WIDTH-1:0] lsu_rdata_o,
  output logic                  data_req_o,
  input  logic                  data_gnt_i,
  output logic [ADDR_WIDTH-1:0] data_addr_o,
  output logic                  data_we_o,
  output logic [3:0]            data_be_o,
  output logic [DATA_WIDTH-1:0] data_wdata_o,
  input  logic                  data_rvalid_i,
  input  logic [DATA_WIDTH-1:0] data_rdata_i
);

  lsu_state_e            r_state;
  lsu_state_e            w_state_next;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic                  r_we;
  logic [1:0]            r_type;
  logic                  r_sign_ext;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic                  r_done;
  logic                  r_err;
  logic [DATA_WIDTH-1:0] r_rdata;

  logic                  w_accept;
  logic                  w_bad_access;
  logic                  w_resp;
  logic [3:0]            w_be;
  logic [DATA_WIDTH-1:0] w_wdata_lanes;
  logic [DATA_WIDTH-1:0] w_rdata_aligned;

  assign w_accept = (r_state == IDLE) && lsu_req_i;
  assign w_resp   = (r_state == WAIT_RVALID) && data_rvalid_i;

  // Alignment is judged on the live request so the error path skips the bus.
  assign w_bad_access = (lsu_type_i == DATA_TYPE_HALF && lsu_addr_i[0]) ||
                        (lsu_type_i == DATA_TYPE_WORD && lsu_addr_i[1:0] != 2'b00) ||
                        (lsu_type_i == 2'b11);

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:        if (lsu_req_i) w_state_next = w_bad_access ? ERR : REQ;
      REQ:         if (data_gnt_i) w_state_next = WAIT_RVALID;
      WAIT_RVALID: if (data_rvalid_i) w_state_next = IDLE;
      ERR:         w_state_next = IDLE;
      default:     w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_addr     <= '0;
      r_we       <= 1'b0;
      r_type     <= 2'b00;
      r_sign_ext <= 1'b0;
      r_wdata    <= '0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_rdata    <= '0;
    end else begin
      r_state <= w_state_next;
      r_done  <= w_resp || (r_state == ERR);
      r_err   <= (r_state == ERR);
      if (w_accept) begin
        r_addr     <= lsu_addr_i;
        r_we       <= lsu_we_i;
        r_type     <= lsu_type_i;
        r_sign_ext <= lsu_sign_ext_i;
        r_wdata    <= lsu_wdata_i;
      end
      if (w_resp && !r_we) r_rdata <= w_rdata_aligned;
    end
  end

  always_comb begin
    w_be = 4'b0000;
    case (r_type)
      DATA_TYPE_BYTE: w_be = 4'b0001 << r_addr[1:0];
      DATA_TYPE_HALF: w_be = r_addr[1] ? 4'b1100 : 4'b0011;
      DATA_TYPE_WORD: w_be = 4'b1111;
      default:        w_be = 4'b0000;
    endcase
  end

  // Replicating lanes lets memory pick the lane purely from the byte enables.
  always_comb begin
    w_wdata_lanes = r_wdata;
    case (r_type)
      DATA_TYPE_BYTE: w_wdata_lanes = {4{r_wdata[7:0]}};
      DATA_TYPE_HALF: w_wdata_lanes = {2{r_wdata[15:0]}};
      default:        w_wdata_lanes = r_wdata;
    endcase
  end

  lsu_rdata_align u_rdata_align (
    .rdata     (data_rdata_i),
    .offset    (r_addr[1:0]),
    .data_type (r_type),
    .sign_ext  (r_sign_ext),
    .result    (w_rdata_aligned)
  );

  assign lsu_busy_o   = (r_state != IDLE);
  assign lsu_done_o   = r_done;
  assign lsu_err_o    = r_err;
  assign lsu_rdata_o  = r_rdata;
  assign data_req_o   = (r_state == REQ);
  assign data_addr_o  = {r_addr[ADDR_WIDTH-1:2], 2'b00};
  assign data_we_o    = (r_state == REQ) && r_we;
  assign data_be_o    = (r_state == REQ) ? w_be : 4'b0000;
  assign data_wdata_o = w_wdata_lanes;

endmodule
`default_nettype wire

// File: tb/tb_lsu.sv
`default_nettype none
// ============================================================================
// tb_lsu : scoreboard bench for the load-store unit
// Revision 1.0
// ============================================================================
module tb_lsu;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        lsu_req_i = 1'b0;
  logic        lsu_we_i = 1'b0;
  logic [1:0]  lsu_type_i = 2'b00;
  logic        lsu_sign_ext_i = 1'b0;
  logic [31:0] lsu_addr_i = '0;
  logic [31:0] lsu_wdata_i = '0;
  logic        lsu_busy_o;
  logic        lsu_done_o;
  logic        lsu_err_o;
  logic [31:0] lsu_rdata_o;
  logic        data_req_o;
  logic        data_gnt_i = 1'b0;
  logic [31:0] data_addr_o;
  logic        data_we_o;
  logic [3:0]  data_be_o;
  logic [31:0] data_wdata_o;
  logic        data_rvalid_i = 1'b0;
  logic [31:0] data_rdata_i = '0;

  typedef struct packed {
    logic        err;
    logic [31:0] rdata;
  } sb_item_t;

  sb_item_t    sb[$];
  sb_item_t    r_item;
  int          n_checks = 0;
  int          n_pass = 0;
  int          done_count = 0;
  logic [31:0] last_rdata = '0;

  always #5 clk = ~clk;

  lsu #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .lsu_req_i      (lsu_req_i),
    .lsu_we_i       (lsu_we_i),
    .lsu_type_i     (lsu_type_i),
    .lsu_sign_ext_i (lsu_sign_ext_i),
    .lsu_addr_i     (lsu_addr_i),
    .lsu_wdata_i    (lsu_wdata_i),
    .lsu_busy_o     (lsu_busy_o),
    .lsu_done_o     (lsu_done_o),
    .lsu_err_o      (lsu_err_o),
    .lsu_rdata_o    (lsu_rdata_o),
    .data_req_o     (data_req_o),
    .data_gnt_i     (data_gnt_i),
    .data_addr_o    (data_addr_o),
    .data_we_o      (data_we_o),
    .data_be_o      (data_be_o),
    .data_wdata_o   (data_wdata_o),
    .data_rvalid_i  (data_rvalid_i),
    .data_rdata_i   (data_rdata_i)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Every completion pops one expectation pushed when its access was issued.
  always @(negedge clk) begin
    if (rst_n && lsu_done_o) begin
      done_count++;
      if (sb.size() == 0) begin
        check_eq("sb_spurious_done", 32'd1, 32'd0);
      end else begin
        r_item = sb.pop_front();
        check_eq("sb_err", {31'd0, lsu_err_o}, {31'd0, r_item.err});
        check_eq("sb_rdata", lsu_rdata_o, r_item.rdata);
      end
    end
  end

  task automatic do_access(
    input logic        we,
    input logic [1:0]  typ,
    input logic        sext,
    input logic [31:0] addr,
    input logic [31:0] wdata,
    input int          gnt_dly,
    input int          rv_dly,
    input logic [31:0] mem,
    input logic [3:0]  exp_be,
    input logic [31:0] exp_wdata,
    input logic [31:0] exp_rdata,
    input logic        exp_err
  );
    sb_item_t it;
    int       start;
    start = done_count;
    it.err = exp_err;
    if (!exp_err && !we) last_rdata = exp_rdata;
    it.rdata = last_rdata;
    sb.push_back(it);

    lsu_req_i = 1'b1; lsu_we_i = we; lsu_type_i = typ; lsu_sign_ext_i = sext;
    lsu_addr_i = addr; lsu_wdata_i = wdata;
    step();
    lsu_req_i = 1'b0; lsu_wdata_i = $urandom; lsu_addr_i = $urandom;
    if (exp_err) begin
      check_eq("err_no_req", {31'd0, data_req_o}, 32'd0);
      check_eq("err_busy", {31'd0, lsu_busy_o}, 32'd1);
      step();
      check_eq("err_done", {31'd0, lsu_done_o}, 32'd1);
      check_eq("err_flag", {31'd0, lsu_err_o}, 32'd1);
      check_eq("err_no_req2", {31'd0, data_req_o}, 32'd0);
    end else begin
      for (int i = 0; i <= gnt_dly; i++) begin
        check_eq("req", {31'd0, data_req_o}, 32'd1);
        check_eq("busy", {31'd0, lsu_busy_o}, 32'd1);
        check_eq("addr", data_addr_o, {addr[31:2], 2'b00});
        check_eq("we", {31'd0, data_we_o}, {31'd0, we});
        check_eq("be", {28'd0, data_be_o}, {28'd0, exp_be});
        if (we) check_eq("wdata", data_wdata_o, exp_wdata);
        if (i == gnt_dly) data_gnt_i = 1'b1;
        step();
        data_gnt_i = 1'b0;
      end
      check_eq("req_dropped", {31'd0, data_req_o}, 32'd0);
      repeat (rv_dly) step();
      data_rvalid_i = 1'b1; data_rdata_i = mem;
      step();
      data_rvalid_i = 1'b0; data_rdata_i = $urandom;
      check_eq("done_lat", {31'd0, lsu_done_o}, 32'd1);
      check_eq("done_no_err", {31'd0, lsu_err_o}, 32'd0);
      check_eq("done_idle", {31'd0, lsu_busy_o}, 32'd0);
    end
    step();
    check_eq("one_done", done_count, start + 1);
    check_eq("done_pulse", {31'd0, lsu_done_o}, 32'd0);
  endtask

  initial begin
    int start;
    step(); step();
    check_eq("rst_busy", {31'd0, lsu_busy_o}, 32'd0);
    check_eq("rst_done", {31'd0, lsu_done_o}, 32'd0);
    check_eq("rst_err", {31'd0, lsu_err_o}, 32'd0);
    check_eq("rst_rdata", lsu_rdata_o, 32'd0);
    check_eq("rst_req", {31'd0, data_req_o}, 32'd0);
    check_eq("rst_addr", data_addr_o, 32'd0);
    check_eq("rst_be", {28'd0, data_be_o}, 32'd0);
    check_eq("rst_wdata", data_wdata_o, 32'd0);
    rst_n = 1'b1;

    // Stray response straight after reset must not complete anything.
    data_rvalid_i = 1'b1; data_rdata_i = 32'h1234_5678;
    step();
    data_rvalid_i = 1'b0;
    step();
    check_eq("stray_rv_done", done_count, 32'd0);
    check_eq("stray_rv_rdata", lsu_rdata_o, 32'd0);

    //         we    typ    sx    addr          wdata         g  r  mem           be       wdata_exp     rdata_exp     err
    do_access(1'b1, 2'b10, 1'b0, 32'h0000_1004, 32'hDEAD_BEEF, 0, 1, 32'h0,        4'b1111, 32'hDEAD_BEEF, 32'h0,        1'b0);
    do_access(1'b0, 2'b00, 1'b1, 32'h0000_2003, 32'h0,        0, 0, 32'h80FF_7F01, 4'b1000, 32'h0,        32'hFFFF_FF80, 1'b0);
    do_access(1'b0, 2'b00, 1'b0, 32'h0000_2003, 32'h0,        0, 0, 32'h80FF_7F01, 4'b1000, 32'h0,        32'h0000_0080, 1'b0);
    do_access(1'b1, 2'b01, 1'b0, 32'h0000_3002, 32'h0000_ABCD, 0, 0, 32'h0,        4'b1100, 32'hABCD_ABCD, 32'h0,        1'b0);
    do_access(1'b0, 2'b01, 1'b1, 32'h0000_2002, 32'h0,        1, 2, 32'h80FF_7F01, 4'b1100, 32'h0,        32'hFFFF_80FF, 1'b0);
    do_access(1'b0, 2'b01, 1'b1, 32'h0000_2000, 32'h0,        0, 0, 32'h80FF_7F01, 4'b0011, 32'h0,        32'h0000_7F01, 1'b0);
    do_access(1'b0, 2'b00, 1'b1, 32'h0000_2001, 32'h0,        0, 0, 32'h80FF_7F01, 4'b0010, 32'h0,        32'h0000_007F, 1'b0);
    do_access(1'b1, 2'b00, 1'b0, 32'h0000_5001, 32'h1234_5678, 0, 0, 32'h0,        4'b0010, 32'h7878_7878, 32'h0,        1'b0);
    // Grant stall: request fields must hold for the whole wait.
    do_access(1'b1, 2'b10, 1'b0, 32'h0000_8008, 32'hA5A5_5A5A, 5, 0, 32'h0,        4'b1111, 32'hA5A5_5A5A, 32'h0,        1'b0);
    do_access(1'b0, 2'b10, 1'b0, 32'h0000_9000, 32'h0,        2, 3, 32'hC001_D00D, 4'b1111, 32'h0,        32'hC001_D00D, 1'b0);
    do_access(1'b0, 2'b10, 1'b0, 32'h0000_4001, 32'h0,        0, 0, 32'h0,        4'b0000, 32'h0,        32'h0,        1'b1);
    do_access(1'b0, 2'b11, 1'b0, 32'h0000_4000, 32'h0,        0, 0, 32'h0,        4'b0000, 32'h0,        32'h0,        1'b1);
    do_access(1'b1, 2'b01, 1'b0, 32'h0000_4003, 32'h0,        0, 0, 32'h0,        4'b0000, 32'h0,        32'h0,        1'b1);

    // Reset while waiting for the response aborts the access silently.
    start = done_count;
    lsu_req_i = 1'b1; lsu_we_i = 1'b0; lsu_type_i = 2'b10; lsu_addr_i = 32'h0000_6000;
    step();
    lsu_req_i = 1'b0; data_gnt_i = 1'b1;
    step();
    data_gnt_i = 1'b0;
    check_eq("abort_busy_pre", {31'd0, lsu_busy_o}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("abort_busy", {31'd0, lsu_busy_o}, 32'd0);
    check_eq("abort_rdata", lsu_rdata_o, 32'd0);
    check_eq("abort_addr", data_addr_o, 32'd0);
    check_eq("abort_done", {31'd0, lsu_done_o}, 32'd0);
    last_rdata = 32'd0;
    step();
    rst_n = 1'b1;
    data_rvalid_i = 1'b1; data_rdata_i = 32'hCAFE_F00D;
    step();
    data_rvalid_i = 1'b0;
    check_eq("abort_no_done", {31'd0, lsu_done_o}, 32'd0);
    step();
    check_eq("abort_no_done2", {31'd0, lsu_done_o}, 32'd0);
    check_eq("abort_done_cnt", done_count, start);
    check_eq("abort_rdata_hold", lsu_rdata_o, 32'd0);

    do_access(1'b0, 2'b00, 1'b0, 32'h0000_7002, 32'h0,        0, 0, 32'h11AA_2233, 4'b0100, 32'h0,        32'h0000_00AA, 1'b0);

    repeat (3) step();
    check_eq("sb_empty", sb.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
